spi_cmd_counter: RTL and testbench
==================================

Name: spi_cmd_counter

Overview:
- Command stage directly downstream of the SPI slave on the iCEstick.
- Consumes the received byte (spi data_incoming) and the chip-enable line, and executes one command per completed SPI transaction in the clk domain.
- Maintains an 8-bit counter whose value drives spi data_outgoing, so the host reads it back on the next transfer.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on ce0 (legal values 2..3).
- TICK_DIV, 12000000, clk cycles per auto-tick (1 s at 12 MHz); only used with AUTO_TICK_EN.

Ports:
- clk  input  1  system clock, 12 MHz
- rst_n  input  1  asynchronous active-low reset
- ce0  input  1  SPI chip enable from pin, async, active-low; rising edge marks end of a transaction
- rx_byte  input  8  received byte from the SPI slave; quasi-static once ce0 is high
- tx_byte  output  8  byte returned to the SPI slave on the next transfer; equals count
- count  output  8  current counter value (LED/debug)
- arg_pending  output  1  high while a LOAD command awaits its data byte
- cmd_err  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: count=0x00, tx_byte=0x00, arg_pending=0, cmd_err=0, FSM=IDLE. All synchronizer flops reset to 1 (ce0 idle level), so no spurious edge occurs at reset release.
- Sync: ce0 passes through SYNC_STAGES flops giving ce0_s, then a one-flop delay giving ce0_d.
- Byte-done detection: byte_done = ce0_s & ~ce0_d, one cycle wide.
- Byte sampling: rx_byte is sampled only in the byte_done cycle.
- Latency: with ce0 high at clk edge E0, count/arg_pending/cmd_err update at edge E0+SYNC_STAGES+1 and are visible from then on.
- FSM state IDLE, on byte_done with opcode = rx_byte:
  - 0x00 NOP: no change.
  - 0x01 INC: count+1, wraps 0xFF->0x00.
  - 0x02 DEC: count-1, wraps 0x00->0xFF.
  - 0x03 CLR: count=0.
  - 0x10 LOAD: go to ARG, set arg_pending=1.
  - 0x20 TICK_ON / 0x21 TICK_OFF: see Optional Feature. When the feature is compiled out, these are treated as undefined.
  - Any other value: cmd_err pulses for 1 cycle; count unchanged.
- FSM state ARG, on byte_done: count=rx_byte (any value, including opcode values); arg_pending=0; go to IDLE. No timeout; only reset aborts.
- tx_byte: registered copy of count, updated on the same edge as count. It must be stable while ce0 is low.
- Transactions shorter than 8 bits: still one byte_done, and whatever rx_byte holds is used. Protocol correctness is the host's responsibility.
- Back-to-back transactions: ce0 high or low phases shorter than SYNC_STAGES+1 clk cycles may be missed. The minimum ce0 high time is therefore SYNC_STAGES+1 clk cycles.
- Reset mid-ARG: async return to IDLE; the pending LOAD is discarded.
- Width rule: all arithmetic is 8-bit modulo 256; no saturation.

Optional Feature:
- Macro: SPI_CMD_COUNTER_AUTO_TICK_EN.
- Defined:
  - Adds a tick_en flop (reset 0) and a prescaler of width clog2(TICK_DIV), reset 0.
  - 0x20 sets tick_en; 0x21 clears tick_en and zeroes the prescaler.
  - While tick_en=1, the prescaler counts 0..TICK_DIV-1. On wrap it emits a tick that does count+1 (modulo 256).
  - If a tick and a byte_done command coincide, the command wins and the tick is dropped; the prescaler keeps running.
- Undefined: no prescaler logic; 0x20/0x21 raise cmd_err.

Decomposition:
- Package spi_cmd_pkg holds:
  - opcode localparams OP_NOP, OP_INC, OP_DEC, OP_CLR, OP_LOAD, OP_TICK_ON, OP_TICK_OFF;
  - FSM state encoding ST_IDLE, ST_ARG.
- Sub-module sync_edge: SYNC_STAGES-deep synchronizer plus rising-edge pulse, reset value 1. It is reusable for other pin inputs (e.g. buttons).

Test Plan:
- Reset: rst_n low mid-run with count=0x37 -> count=0x00, tx_byte=0x00, arg_pending=0 immediately (async); no byte_done after release with ce0=1.
- Wrap: 256 transactions of 0x01 -> count returns to 0x00. Then one 0x02 -> count=0xFF, tx_byte=0xFF exactly SYNC_STAGES+1 edges after ce0 is sampled high.
- LOAD: send 0x10 -> arg_pending=1. Send 0x02 -> count=0x02 (treated as data), arg_pending=0. Send 0x10, assert rst_n low, release, send 0x05 -> cmd_err pulse, count=0x00.
- Undefined opcode: send 0x7F -> cmd_err high exactly one cycle, count unchanged.
- Sync robustness: ce0 high pulse of SYNC_STAGES+1 cycles -> exactly one command executed. Pulse of 1 cycle with SYNC_STAGES=2 -> at most one command and no double-execute. Jitter ce0 edges relative to clk -> count never double-steps.
- With AUTO_TICK_EN, TICK_DIV=4: send 0x20 -> count increments every 4 clk cycles. Force a 0x03 on a tick cycle -> count=0x00, not 0x01. Send 0x21 -> count frozen.

Source files
------------

// File: rtl/spi_cmd_counter_pkg.sv
// Shared opcodes and FSM state encoding for the SPI command counter.
package spi_cmd_pkg;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_INC      = 8'h01;
  localparam logic [7:0] OP_DEC      = 8'h02;
  localparam logic [7:0] OP_CLR      = 8'h03;
  localparam logic [7:0] OP_LOAD     = 8'h10;
  localparam logic [7:0] OP_TICK_ON  = 8'h20;
  localparam logic [7:0] OP_TICK_OFF = 8'h21;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ARG  = 1'b1
  } state_t;

endpackage

// File: rtl/spi_cmd_counter_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with a registered rising-edge pulse.
// All synchronizer flops reset to RESET_VAL (the pin's idle level) so reset release never looks like an edge.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/spi_cmd_counter.sv
// Executes one SPI command byte per completed transaction and exposes an 8-bit counter.
// Optional auto-increment prescaler is compiled in with SPI_CMD_COUNTER_AUTO_TICK_EN.
module spi_cmd_counter
  import spi_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce0,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic [7:0] count,
  output logic       arg_pending,
  output logic       cmd_err
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
    $error("spi_cmd_counter: SYNC_STAGES must be 2 or 3");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("spi_cmd_counter: TICK_DIV must be at least 1");
  end

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] tx_q;
  logic       cmd_err_q, cmd_err_d;
  logic       byte_done;
  logic       tick;

  // The rising edge of chip enable marks the end of a transaction.
  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_ce0_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ce0),
    .rise  (byte_done)
  );

`ifdef SPI_CMD_COUNTER_AUTO_TICK_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic          tick_en_q, tick_en_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_on, tick_off;

  assign tick = tick_en_q && (presc_q == PRESC_MAX);

  always_comb begin
    tick_en_d = tick_en_q;
    presc_d   = presc_q;
    if (tick_en_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (tick_on) begin
      tick_en_d = 1'b1;
    end
    if (tick_off) begin
      tick_en_d = 1'b0;
      presc_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_en_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      tick_en_q <= tick_en_d;
      presc_q   <= presc_d;
    end
  end
`else
  assign tick = 1'b0;
`endif

  // A command in the same cycle as a tick overrides it; the tick is simply lost.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cmd_err_d = 1'b0;
`ifdef SPI_CMD_COUNTER_AUTO_TICK_EN
    tick_on   = 1'b0;
    tick_off  = 1'b0;
`endif
    if (tick) begin
      count_d = count_q + 8'd1;
    end
    if (byte_done) begin
      count_d = count_q;
      case (state_q)
        ST_IDLE: begin
          case (rx_byte)
            OP_NOP:  count_d = count_q;
            OP_INC:  count_d = count_q + 8'd1;
            OP_DEC:  count_d = count_q - 8'd1;
            OP_CLR:  count_d = 8'h00;
            OP_LOAD: state_d = ST_ARG;
`ifdef SPI_CMD_COUNTER_AUTO_TICK_EN
            OP_TICK_ON:  tick_on  = 1'b1;
            OP_TICK_OFF: tick_off = 1'b1;
`endif
            default: cmd_err_d = 1'b1;
          endcase
        end
        ST_ARG: begin
          count_d = rx_byte;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= 8'h00;
      tx_q      <= 8'h00;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tx_q      <= count_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign count       = count_q;
  assign tx_byte     = tx_q;
  assign arg_pending = (state_q == ST_ARG);
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_spi_cmd_counter.sv
// Self-checking bench for spi_cmd_counter: randomized SPI transactions against a transaction-level model.
// Tick scenarios run only when SPI_CMD_COUNTER_AUTO_TICK_EN is defined.
module tb_spi_cmd_counter;

  localparam int SYNC_STAGES = 2;
  localparam int TICK_DIV    = 4;
  localparam int LAT         = SYNC_STAGES + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce0 = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] tx_byte;
  logic [7:0] count;
  logic       arg_pending;
  logic       cmd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;

  int model_count   = 0;
  bit model_pending = 1'b0;

  spi_cmd_counter #(
    .SYNC_STAGES (SYNC_STAGES),
    .TICK_DIV    (TICK_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce0         (ce0),
    .rx_byte     (rx_byte),
    .tx_byte     (tx_byte),
    .count       (count),
    .arg_pending (arg_pending),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  // Each negedge with cmd_err high counts once, so a one-cycle pulse adds exactly one.
  always @(negedge clk) if (cmd_err === 1'b1) err_seen++;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Command semantics as the host sees them, one call per completed transaction.
  task automatic model_apply(input logic [7:0] b, output bit exp_err);
    exp_err = 1'b0;
    if (model_pending) begin
      model_count   = b;
      model_pending = 1'b0;
    end else begin
      case (b)
        8'h00: ;
        8'h01: model_count = (model_count + 1) % 256;
        8'h02: model_count = (model_count + 255) % 256;
        8'h03: model_count = 0;
        8'h10: model_pending = 1'b1;
`ifdef SPI_CMD_COUNTER_AUTO_TICK_EN
        8'h20, 8'h21: ;
`endif
        default: exp_err = 1'b1;
      endcase
    end
  endtask

  task automatic model_reset();
    model_count   = 0;
    model_pending = 1'b0;
  endtask

  // One SPI transaction: low phase with junk data, final byte settles, then ce0 rises and is held.
  task automatic drive_txn(input logic [7:0] b, input int low_cyc, input int high_cyc);
    ce0     = 1'b0;
    rx_byte = 8'($urandom);
    repeat (low_cyc) @(negedge clk);
    rx_byte = b;
    @(negedge clk);
    ce0 = 1'b1;
    repeat (high_cyc) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bit e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_count: got %h required 00", count); end
    n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_tx: got %h required 00", tx_byte); end
    n_checks++; if (arg_pending !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pending: got %b required 0", arg_pending); end
    n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b required 0", cmd_err); end

    drive_txn(8'h10, 2, LAT + 2); model_apply(8'h10, e);
    drive_txn(8'h37, 2, LAT + 2); model_apply(8'h37, e);
    n_checks++; if (count !== 8'h37) begin n_fail++; $display("[TB] FAIL preload_37: got %h required 37", count); end
    drive_txn(8'h10, 2, LAT + 2); model_apply(8'h10, e);
    n_checks++; if (arg_pending !== 1'b1) begin n_fail++; $display("[TB] FAIL pending_before_reset: got %b required 1", arg_pending); end

    pulse_reset();
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("[TB] FAIL async_reset_count: got %h required 00", count); end
    n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("[TB] FAIL async_reset_tx: got %h required 00", tx_byte); end
    n_checks++; if (arg_pending !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_pending: got %b required 0", arg_pending); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int err0 = err_seen;
      repeat (10) @(negedge clk);
      n_checks++; if (count !== 8'h00) begin n_fail++; $display("[TB] FAIL no_edge_after_reset: got %h required 00", count); end
      n_checks++; if (err_seen != err0) begin n_fail++; $display("[TB] FAIL no_err_after_reset: got %0d pulses required 0", err_seen - err0); end
    end
  endtask

  task automatic test_wrap();
    bit e;
    for (int i = 0; i < 256; i++) begin
      drive_txn(8'h01, 1 + $urandom_range(0, 1), LAT + 2);
      model_apply(8'h01, e);
    end
    n_checks++; if (count !== 8'(model_count)) begin n_fail++; $display("[TB] FAIL wrap_inc_count: got %h required %h", count, 8'(model_count)); end
    n_checks++; if (tx_byte !== 8'(model_count)) begin n_fail++; $display("[TB] FAIL wrap_inc_tx: got %h required %h", tx_byte, 8'(model_count)); end

    // DEC from zero with exact latency measured from the first edge that sees ce0 high.
    ce0     = 1'b0;
    rx_byte = 8'h02;
    repeat (3) @(negedge clk);
    ce0 = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      logic [7:0] exp;
      @(posedge clk);
      #1;
      exp = (k < LAT) ? 8'h00 : 8'hFF;
      n_checks++; if (count !== exp) begin n_fail++; $display("[TB] FAIL dec_latency_count edge+%0d: got %h required %h", k, count, exp); end
      n_checks++; if (tx_byte !== exp) begin n_fail++; $display("[TB] FAIL dec_latency_tx edge+%0d: got %h required %h", k, tx_byte, exp); end
    end
    model_apply(8'h02, e);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load();
    bit e;
    int err0;
    drive_txn(8'h10, 2, LAT + 2); model_apply(8'h10, e);
    n_checks++; if (arg_pending !== 1'b1) begin n_fail++; $display("[TB] FAIL load_pending_set: got %b required 1", arg_pending); end
    n_checks++; if (count !== 8'(model_count)) begin n_fail++; $display("[TB] FAIL load_count_hold: got %h required %h", count, 8'(model_count)); end
    drive_txn(8'h02, 2, LAT + 2); model_apply(8'h02, e);
    n_checks++; if (count !== 8'h02) begin n_fail++; $display("[TB] FAIL load_data_02: got %h required 02", count); end
    n_checks++; if (arg_pending !== 1'b0) begin n_fail++; $display("[TB] FAIL load_pending_clear: got %b required 0", arg_pending); end

    drive_txn(8'h10, 2, LAT + 2); model_apply(8'h10, e);
    pulse_reset();
    n_checks++; if (arg_pending !== 1'b0) begin n_fail++; $display("[TB] FAIL load_reset_abort: got %b required 0", arg_pending); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    err0 = err_seen;
    drive_txn(8'h05, 2, LAT + 2); model_apply(8'h05, e);
    n_checks++; if (err_seen - err0 != 1) begin n_fail++; $display("[TB] FAIL load_after_reset_err: got %0d pulses required 1", err_seen - err0); end
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("[TB] FAIL load_after_reset_count: got %h required 00", count); end
  endtask

  task automatic test_undefined();
    logic [7:0] ops [$];
    bit e;
    int err0;
    ops = '{8'h7F, 8'hFF, 8'h11, 8'h04};
`ifndef SPI_CMD_COUNTER_AUTO_TICK_EN
    ops.push_back(8'h20);
    ops.push_back(8'h21);
`endif
    drive_txn(8'h01, 2, LAT + 2); model_apply(8'h01, e);
    foreach (ops[i]) begin
      err0 = err_seen;
      drive_txn(ops[i], 2, LAT + 2);
      model_apply(ops[i], e);
      n_checks++; if (err_seen - err0 != 1) begin n_fail++; $display("[TB] FAIL undef_err_%h: got %0d pulse cycles required 1", ops[i], err_seen - err0); end
      n_checks++; if (count !== 8'(model_count)) begin n_fail++; $display("[TB] FAIL undef_count_%h: got %h required %h", ops[i], count, 8'(model_count)); end
    end
  endtask

  task automatic test_random();
    bit e;
    int err0;
    logic [7:0] b;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0: b = 8'h00;
        1, 2: b = 8'h01;
        3: b = 8'h02;
        4: b = 8'h03;
        5: b = 8'h10;
        default: b = 8'($urandom);
      endcase
`ifdef SPI_CMD_COUNTER_AUTO_TICK_EN
      if (b == 8'h20) b = 8'h01;
`endif
      err0 = err_seen;
      drive_txn(b, 1 + $urandom_range(0, 3), LAT + 2 + $urandom_range(0, 3));
      model_apply(b, e);
      n_checks++; if (count !== 8'(model_count)) begin n_fail++; $display("[TB] FAIL rand_count #%0d op %h: got %h required %h", i, b, count, 8'(model_count)); end
      n_checks++; if (tx_byte !== 8'(model_count)) begin n_fail++; $display("[TB] FAIL rand_tx #%0d op %h: got %h required %h", i, b, tx_byte, 8'(model_count)); end
      n_checks++; if (arg_pending !== model_pending) begin n_fail++; $display("[TB] FAIL rand_pending #%0d op %h: got %b required %b", i, b, arg_pending, model_pending); end
      n_checks++; if ((err_seen - err0) != int'(e)) begin n_fail++; $display("[TB] FAIL rand_err #%0d op %h: got %0d required %0d", i, b, err_seen - err0, e); end
    end
    drive_txn(8'h03, 2, LAT + 2); model_apply(8'h03, e);
  endtask

  task automatic test_sync();
    bit e;
    int d;
    int err0;
    // Minimum legal high phase executes exactly one command.
    drive_txn(8'h01, 2, LAT);
    ce0 = 1'b0;
    repeat (4) @(negedge clk);
    model_apply(8'h01, e);
    n_checks++; if (count !== 8'(model_count)) begin n_fail++; $display("[TB] FAIL min_high_pulse: got %h required %h", count, 8'(model_count)); end
    rx_byte = 8'h00;
    @(negedge clk);
    ce0 = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    model_apply(8'h00, e);

    // A single-cycle high glitch may execute at most once.
    err0 = err_seen;
    ce0 = 1'b0; rx_byte = 8'h01;
    repeat (5) @(negedge clk);
    ce0 = 1'b1;
    @(negedge clk);
    ce0 = 1'b0;
    repeat (6) @(negedge clk);
    rx_byte = 8'h00;
    @(negedge clk);
    ce0 = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    d = (int'(count) - model_count + 256) % 256;
    n_checks++; if (d > 1) begin n_fail++; $display("[TB] FAIL short_pulse_steps: got %0d steps required 0 or 1", d); end
    n_checks++; if (err_seen != err0) begin n_fail++; $display("[TB] FAIL short_pulse_err: got %0d required 0", err_seen - err0); end
    drive_txn(8'h03, 2, LAT + 2); model_apply(8'h03, e);

    // ce0 edges placed at arbitrary times relative to clk.
    for (int i = 0; i < 30; i++) begin
      #($urandom_range(1, 9));
      ce0 = 1'b0;
      rx_byte = 8'h01;
      #(40 + $urandom_range(0, 13));
      ce0 = 1'b1;
      #(50 + $urandom_range(0, 13));
      @(negedge clk);
      model_apply(8'h01, e);
      n_checks++; if (count !== 8'(model_count)) begin n_fail++; $display("[TB] FAIL jitter_step #%0d: got %h required %h", i, count, 8'(model_count)); end
    end
  endtask

`ifdef SPI_CMD_COUNTER_AUTO_TICK_EN
  task automatic test_tick();
    logic [7:0] c0;
    logic [7:0] prev;
    bit found;
    drive_txn(8'h20, 2, LAT + 2);
    c0 = count;
    repeat (10 * TICK_DIV) @(negedge clk);
    n_checks++; if (count !== 8'(c0 + 8'd10)) begin n_fail++; $display("[TB] FAIL tick_rate: got %h required %h", count, 8'(c0 + 8'd10)); end

    // Line up a CLR so it executes on the same edge as a tick.
    ce0 = 1'b0; rx_byte = 8'h03;
    repeat (4) @(negedge clk);
    prev = count;
    found = 1'b0;
    for (int k = 0; k < 2 * TICK_DIV && !found; k++) begin
      @(negedge clk);
      if (count !== prev) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL tick_find: got no tick within %0d cycles required a tick", 2 * TICK_DIV); end
    repeat (TICK_DIV) @(negedge clk);
    ce0 = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("[TB] FAIL tick_collision: got %h required 00", count); end
    repeat (TICK_DIV - 1) @(negedge clk);
    n_checks++; if (count !== 8'h00) begin n_fail++; $display("[TB] FAIL tick_after_clr_hold: got %h required 00", count); end
    @(negedge clk);
    n_checks++; if (count !== 8'h01) begin n_fail++; $display("[TB] FAIL tick_prescaler_kept: got %h required 01", count); end

    drive_txn(8'h21, 2, LAT + 2);
    c0 = count;
    repeat (5 * TICK_DIV) @(negedge clk);
    n_checks++; if (count !== c0) begin n_fail++; $display("[TB] FAIL tick_off_frozen: got %h required %h", count, c0); end

    pulse_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    $display("[TB] spi_cmd_counter bench start, SYNC_STAGES=%0d", SYNC_STAGES);
    test_reset();
    test_wrap();
    test_load();
    test_undefined();
    test_random();
    test_sync();
`ifdef SPI_CMD_COUNTER_AUTO_TICK_EN
    test_tick();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
